// File: rtl/oled_text_pkg.sv
// Screen geometry, FSM encoding and fixed text for the OLED text streamer.
// Latency: none; constants, types and a purely combinational character lookup.
// Backpressure: not applicable.
package oled_text_pkg;

   localparam int         LINE_LEN    = 16;
   localparam int         NUM_LINES   = 4;
   localparam int         FRAME_LEN   = LINE_LEN * NUM_LINES;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;

   typedef enum logic [2:0] {
      IDLE,
      CONV,
      WAIT_LOW,
      SEND,
      DONE
   } state_e;

   // Leftmost character sits in the most significant byte.
   localparam logic [8*LINE_LEN-1:0] LINE_COUNTING = "Counting        ";
   localparam logic [8*LINE_LEN-1:0] LINE_CAND     = "Cand x:         ";
   localparam logic [8*LINE_LEN-1:0] LINE_VOTING   = "Voting          ";
   localparam logic [8*LINE_LEN-1:0] LINE_PRESS    = "Press button    ";

   // Character at frame position idx (line*16 + column) for the given snapshot.
   function automatic logic [7:0] screen_char(input logic        mode,
                                              input logic [5:0]  idx,
                                              input logic [11:0] bcd1,
                                              input logic [11:0] bcd2,
                                              input logic [11:0] bcd3);
      logic [1:0]  line;
      logic [3:0]  col;
      logic [11:0] bcd;
      int          sh;
      line = idx[5:4];
      col  = idx[3:0];
      sh   = 8 * (LINE_LEN - 1 - int'(col));
      case (line)
         2'd1:    bcd = bcd1;
         2'd2:    bcd = bcd2;
         default: bcd = bcd3;
      endcase
      screen_char = ASCII_SPACE;
      if (mode) begin
         if (line == 2'd0)      screen_char = LINE_VOTING[sh +: 8];
         else if (line == 2'd1) screen_char = LINE_PRESS[sh +: 8];
      end else if (line == 2'd0) begin
         screen_char = LINE_COUNTING[sh +: 8];
      end else begin
         case (col)
            4'd5:    screen_char = ASCII_ZERO + {6'd0, line};
            4'd12:   screen_char = ASCII_ZERO + {4'd0, bcd[11:8]};
            4'd13:   screen_char = ASCII_ZERO + {4'd0, bcd[7:4]};
            4'd14:   screen_char = ASCII_ZERO + {4'd0, bcd[3:0]};
            default: screen_char = LINE_CAND[sh +: 8];
         endcase
      end
   endfunction

endpackage

// File: rtl/oled_text_streamer_bin_to_bcd.sv
// Sequential shift-add-3 binary to 3-digit BCD converter.
// Latency: done pulses COUNT_W+1 cycles after start; bcd holds until the next start.
// Backpressure: none; a start while busy restarts the conversion.
module bin_to_bcd #(
   parameter int COUNT_W = 10
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [COUNT_W-1:0] bin,
   output logic               done,
   output logic [11:0]        bcd
);

   localparam int CNT_W = $clog2(COUNT_W + 1);

   logic [11:0]        bcd_q;
   logic [11:0]        adj;
   logic [COUNT_W-1:0] bin_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               done_q;

   // Add 3 to every digit that is 5 or more before the next shift.
   always_comb begin
      adj = bcd_q;
      for (int k = 0; k < 3; k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
   end

   // Load on start, then shift one binary bit into the BCD register per cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bcd_q  <= '0;
         bin_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else if (start) begin
         bcd_q  <= '0;
         bin_q  <= bin;
         cnt_q  <= CNT_W'(COUNT_W);
         done_q <= 1'b0;
      end else if (cnt_q != '0) begin
         bcd_q  <= {adj[10:0], bin_q[COUNT_W-1]};
         bin_q  <= bin_q << 1;
         cnt_q  <= cnt_q - CNT_W'(1);
         done_q <= (cnt_q == CNT_W'(1));
      end else begin
         done_q <= 1'b0;
      end
   end

   assign done = done_q;
   assign bcd  = bcd_q;

endmodule

// File: rtl/oled_text_streamer.sv
// Builds a 64-byte text screen from mode and three tallies and streams it to the OLED controller.
// Latency: 3*(COUNT_W+2) conversion cycles after a change, then one byte per sendDone handshake.
// Backpressure: one byte outstanding; valid is withheld until sendDone from the previous byte falls.
module oled_text_streamer
   import oled_text_pkg::*;
#(
   parameter int COUNT_W   = 10,
   parameter int SAT_VALUE = 999
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               mode,
   input  logic [COUNT_W-1:0] count_1,
   input  logic [COUNT_W-1:0] count_2,
   input  logic [COUNT_W-1:0] count_3,
   output logic [7:0]         sendData,
   output logic               sendDataValid,
   input  logic               sendDone,
   output logic               frame_busy,
   output logic               frame_done
);

   localparam logic [COUNT_W-1:0] SAT = COUNT_W'(SAT_VALUE);

   state_e                  state_q, state_d;
   logic [5:0]              idx_q, idx_d;
   logic                    dirty_q, dirty_d;
   logic                    snap_mode_q, snap_mode_d;
   logic [2:0][COUNT_W-1:0] snap_cnt_q, snap_cnt_d;
   logic [2:0][COUNT_W-1:0] cur_cnt;
   logic [1:0]              sel_q, sel_d;
   logic                    run_q, run_d;
   logic [2:0][11:0]        bcd_q, bcd_d;
   logic [7:0]              data_q, data_d;
   logic                    valid_q, valid_d;
   logic                    conv_start, conv_done;
   logic [COUNT_W-1:0]      conv_raw, conv_bin;
   logic [11:0]             conv_bcd;

   assign cur_cnt  = {count_3, count_2, count_1};
   assign conv_raw = snap_cnt_q[sel_q];
   assign conv_bin = (conv_raw > SAT) ? SAT : conv_raw;

   bin_to_bcd #(.COUNT_W(COUNT_W)) u_bcd (
      .clock (clock),
      .reset (reset),
      .start (conv_start),
      .bin   (conv_bin),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   // Next-state logic: change detect, tally conversion and the byte handshake.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      dirty_d     = dirty_q | (mode != snap_mode_q) | (cur_cnt != snap_cnt_q);
      snap_mode_d = snap_mode_q;
      snap_cnt_d  = snap_cnt_q;
      sel_d       = sel_q;
      run_d       = run_q;
      bcd_d       = bcd_q;
      data_d      = data_q;
      valid_d     = valid_q;
      conv_start  = 1'b0;
      case (state_q)
         IDLE: begin
            if (dirty_q) begin
               snap_mode_d = mode;
               snap_cnt_d  = cur_cnt;
               dirty_d     = 1'b0;
               sel_d       = 2'd0;
               run_d       = 1'b0;
               state_d     = CONV;
            end
         end
         CONV: begin
            if (!run_q) begin
               conv_start = 1'b1;
               run_d      = 1'b1;
            end else if (conv_done) begin
               bcd_d[sel_q] = conv_bcd;
               run_d        = 1'b0;
               if (sel_q == 2'd2) begin
                  sel_d   = 2'd0;
                  state_d = WAIT_LOW;
               end else begin
                  sel_d = sel_q + 2'd1;
               end
            end
         end
         WAIT_LOW: begin
            if (!sendDone) begin
               data_d  = screen_char(snap_mode_q, idx_q, bcd_q[0], bcd_q[1], bcd_q[2]);
               valid_d = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            if (sendDone) begin
               valid_d = 1'b0;
               idx_d   = idx_q + 6'd1;
               state_d = (idx_q == 6'(FRAME_LEN - 1)) ? DONE : WAIT_LOW;
            end
         end
         DONE: begin
            idx_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset leaves dirty set so a frame goes out after reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         dirty_q     <= 1'b1;
         snap_mode_q <= 1'b0;
         snap_cnt_q  <= '0;
         sel_q       <= '0;
         run_q       <= 1'b0;
         bcd_q       <= '0;
         data_q      <= ASCII_SPACE;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         dirty_q     <= dirty_d;
         snap_mode_q <= snap_mode_d;
         snap_cnt_q  <= snap_cnt_d;
         sel_q       <= sel_d;
         run_q       <= run_d;
         bcd_q       <= bcd_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
      end
   end

   assign sendData      = data_q;
   assign sendDataValid = valid_q;
   assign frame_busy    = (state_q == CONV) || (state_q == WAIT_LOW) || (state_q == SEND);
   assign frame_done    = (state_q == DONE);

endmodule

// File: tb/tb_oled_text_streamer.sv
module tb_oled_text_streamer;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       mode = 1'b0;
   logic [9:0] count_1 = '0, count_2 = '0, count_3 = '0;
   logic [7:0] sendData;
   logic       sendDataValid;
   logic       sendDone;
   logic       frame_busy;
   logic       frame_done;

   oled_text_streamer #(.COUNT_W(10), .SAT_VALUE(999)) dut (
      .clock         (clock),
      .reset         (reset),
      .mode          (mode),
      .count_1       (count_1),
      .count_2       (count_2),
      .count_3       (count_3),
      .sendData      (sendData),
      .sendDataValid (sendDataValid),
      .sendDone      (sendDone),
      .frame_busy    (frame_busy),
      .frame_done    (frame_done)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       mode;
      logic [9:0] c1, c2, c3;
      string      exp;
   } vec_t;

   vec_t       vecs[5];
   int         checks = 0, failures = 0;
   byte        rx[$];
   int         fd_cnt = 0, hold_cycles = 1;
   int         hold_err = 0, stable_err = 0, busy_err = 0, dbl_fd_err = 0;
   logic       prev_valid = 1'b0, prev_fd = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic [7:0] cap;
   int         base;

   // Protocol monitor: data stability, busy while sending, single-cycle frame_done.
   always @(negedge clock) begin
      if (reset) begin
         if (sendDataValid && prev_valid && sendData != prev_data) stable_err++;
         if (sendDataValid && !frame_busy) busy_err++;
         if (frame_done) begin
            fd_cnt++;
            if (prev_fd) dbl_fd_err++;
         end
      end
      prev_valid = sendDataValid;
      prev_data  = sendData;
      prev_fd    = frame_done;
   end

   // Controller model: ack 2 cycles after valid, hold sendDone for hold_cycles.
   initial begin
      sendDone = 1'b0;
      forever begin
         @(negedge clock);
         if (reset && sendDataValid && !sendDone) begin
            cap = sendData;
            repeat (2) @(negedge clock);
            sendDone = 1'b1;
            rx.push_back(cap);
            for (int k = 0; k < hold_cycles; k++) begin
               @(negedge clock);
               if (sendDataValid) hold_err++;
            end
            sendDone = 1'b0;
         end
      end
   end

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic wait_fd(input string name);
      int b;
      int n;
      b = fd_cnt;
      n = 0;
      while (fd_cnt == b && n < 4000) begin
         @(negedge clock); #1;
         n++;
      end
      checks++;
      if (fd_cnt == b) begin
         failures++;
         $display("FAIL %s: no frame_done within %0d cycles, got %0d pulses expected 1", name, n, fd_cnt - b);
      end
   endtask

   task automatic wait_bytes(input string name, input int nb);
      int n;
      n = 0;
      while (rx.size() < nb && n < 4000) begin
         @(negedge clock); #1;
         n++;
      end
      checks++;
      if (rx.size() < nb) begin
         failures++;
         $display("FAIL %s: got %0d bytes expected %0d", name, rx.size(), nb);
      end
   endtask

   task automatic check_frame(input string name, input string exp);
      int  bad;
      byte got;
      bad = -1;
      got = 8'h00;
      for (int i = 0; i < 64; i++) begin
         if (bad < 0 && (i >= rx.size() || rx[i] != exp[i])) begin
            bad = i;
            got = (i < rx.size()) ? rx[i] : 8'h00;
         end
      end
      checks++;
      if (bad >= 0 || rx.size() != 64) begin
         failures++;
         $display("FAIL %s: bytes=%0d first bad index %0d got %h expected %h",
                  name, rx.size(), bad, got, (bad >= 0) ? exp[bad] : 8'h00);
      end
      rx.delete();
   endtask

   task automatic apply(input logic m, input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
      @(negedge clock);
      mode    = m;
      count_1 = a;
      count_2 = b;
      count_3 = c;
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      string sp;
      sp = "                ";
      vecs[0] = '{1'b0, 10'd5, 10'd42, 10'd999,
                  {"Counting        ", "Cand 1:     005 ", "Cand 2:     042 ", "Cand 3:     999 "}};
      vecs[1] = '{1'b1, 10'd5, 10'd42, 10'd999,
                  {"Voting          ", "Press button    ", sp, sp}};
      vecs[2] = '{1'b0, 10'd5, 10'd1023, 10'd7,
                  {"Counting        ", "Cand 1:     005 ", "Cand 2:     999 ", "Cand 3:     007 "}};
      vecs[3] = '{1'b0, 10'd0, 10'd100, 10'd998,
                  {"Counting        ", "Cand 1:     000 ", "Cand 2:     100 ", "Cand 3:     998 "}};
      vecs[4] = '{1'b0, 10'd1000, 10'd500, 10'd1,
                  {"Counting        ", "Cand 1:     999 ", "Cand 2:     500 ", "Cand 3:     001 "}};

      // Reset values while reset is held.
      mode = vecs[0].mode; count_1 = vecs[0].c1; count_2 = vecs[0].c2; count_3 = vecs[0].c3;
      repeat (3) @(negedge clock);
      check_val("rst_sendData", 32'(sendData), 32'h20);
      check_val("rst_valid", 32'(sendDataValid), 32'd0);
      check_val("rst_busy", 32'(frame_busy), 32'd0);
      check_val("rst_done", 32'(frame_done), 32'd0);
      reset = 1'b1;

      // Directed screens.
      for (int i = 0; i < 5; i++) begin
         if (i > 0) apply(vecs[i].mode, vecs[i].c1, vecs[i].c2, vecs[i].c3);
         wait_fd($sformatf("vec%0d_done", i));
         check_frame($sformatf("vec%0d_frame", i), vecs[i].exp);
      end

      // Stable inputs: no further frame.
      base = fd_cnt;
      repeat (80) @(negedge clock);
      check_val("idle_no_frame", 32'(fd_cnt - base), 32'd0);
      check_val("idle_busy", 32'(frame_busy), 32'd0);
      check_val("idle_valid", 32'(sendDataValid), 32'd0);

      // Tally change mid-frame: current frame keeps old snapshot, second frame follows.
      apply(1'b0, 10'd5, 10'd42, 10'd999);
      base = fd_cnt;
      wait_bytes("midchg_reach20", 20);
      count_1 = 10'd6;
      wait_fd("midchg_done1");
      check_frame("midchg_frame1", vecs[0].exp);
      wait_fd("midchg_done2");
      check_frame("midchg_frame2",
                  {"Counting        ", "Cand 1:     006 ", "Cand 2:     042 ", "Cand 3:     999 "});
      repeat (80) @(negedge clock);
      check_val("midchg_pulses", 32'(fd_cnt - base), 32'd2);

      // Long sendDone hold: valid must stay low until sendDone falls.
      hold_cycles = 10;
      apply(1'b0, 10'd6, 10'd42, 10'd3);
      wait_fd("hold_done");
      check_frame("hold_frame",
                  {"Counting        ", "Cand 1:     006 ", "Cand 2:     042 ", "Cand 3:     003 "});
      check_val("hold_valid_low", 32'(hold_err), 32'd0);
      hold_cycles = 1;

      // Reset mid-frame, then a full frame from byte 0.
      apply(1'b0, 10'd6, 10'd42, 10'd4);
      wait_bytes("rst_reach30", 30);
      #2;
      reset = 1'b0;
      #1;
      check_val("midrst_sendData", 32'(sendData), 32'h20);
      check_val("midrst_valid", 32'(sendDataValid), 32'd0);
      check_val("midrst_busy", 32'(frame_busy), 32'd0);
      check_val("midrst_done", 32'(frame_done), 32'd0);
      repeat (5) @(negedge clock);
      reset = 1'b1;
      repeat (10) @(negedge clock);
      rx.delete();
      wait_fd("restart_done");
      check_val("restart_first_byte", (rx.size() > 0) ? 32'(rx[0]) : 32'hFFFF, 32'h43);
      check_frame("restart_frame",
                  {"Counting        ", "Cand 1:     006 ", "Cand 2:     042 ", "Cand 3:     004 "});

      // Protocol invariants over the whole run.
      check_val("data_stable", 32'(stable_err), 32'd0);
      check_val("busy_while_valid", 32'(busy_err), 32'd0);
      check_val("done_single_cycle", 32'(dbl_fd_err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/oled_text_streamer.md
Name: oled_text_streamer

Overview:
- Upstream feeder for the OLED controller's byte handshake (sendData/sendDataValid/sendDone).
- Formats a 4-line × 16-character ASCII screen (64 bytes) from the EVM mode and three candidate tallies, then streams it one byte per handshake.
- Converts each tally to 3 decimal digits with a sequential binary-to-BCD unit.
- Re-sends the screen whenever mode or any tally changes.

Parameters:
- COUNT_W, 10, width of each candidate tally input.
- SAT_VALUE, 999, displayed cap. Tallies above it show as 999.

Ports:
- clock  in  1  system clock, 100 MHz onboard.
- reset  in  1  asynchronous, active-low reset.
- mode  in  1  0 = counting screen, 1 = voting screen.
- count_1  in  COUNT_W  tally for candidate 1.
- count_2  in  COUNT_W  tally for candidate 2.
- count_3  in  COUNT_W  tally for candidate 3.
- sendData  out  8  ASCII byte to the OLED controller.
- sendDataValid  out  1  byte-valid to the controller.
- sendDone  in  1  controller byte acknowledge.
- frame_busy  out  1  high while a frame is being converted or sent.
- frame_done  out  1  one-cycle pulse after the 64th byte is acknowledged.

Behaviour:
- Reset (reset=0, asynchronous): outputs and registers clear as follows.
  - sendData=8'h20, sendDataValid=0, frame_busy=0, frame_done=0.
  - byte index=0, dirty=1, so one frame is sent after reset.
- Change detect: every cycle, compare {mode,count_1..3} with the last snapshot. Any difference sets dirty.
- States:
  - IDLE: if dirty, capture the snapshot, clear dirty, go to CONV. frame_busy=1 from the next cycle.
  - CONV: run bin_to_bcd on count_1, count_2, count_3 in turn (each first saturated to SAT_VALUE). Each conversion takes COUNT_W+1 cycles. Store 3 BCD digits per candidate, then go to WAIT_LOW.
  - WAIT_LOW: wait for sendDone=0, then drive sendData=char(index), sendDataValid=1, go to SEND.
  - SEND: hold sendData stable. On sendDone=1, drop sendDataValid in the next cycle and increment index.
    - index was 63 → go to DONE.
    - otherwise → go to WAIT_LOW.
  - DONE: frame_done=1 for one cycle, frame_busy=0, index=0, go to IDLE.
- Frame content is taken from the snapshot only. Input changes mid-frame set dirty and never alter the frame in flight; a new frame follows immediately after DONE.
- Screen layout (index = line*16 + column; unused columns are spaces 8'h20):
  - mode=0:
    - line0 "Counting".
    - lines 1-3 "Cand N:     DDD " with N = '1'..'3' and DDD = hundreds, tens, units digits.
    - Leading zeros shown: 7 → "007".
  - mode=1: line0 "Voting", line1 "Press button", lines 2-3 all spaces.
- Digit ASCII: 8'h30 + BCD nibble.
- Handshake rule: never assert sendDataValid while sendDone=1 from the previous byte. At most one byte is outstanding.
- Reset mid-frame aborts immediately: outputs return to reset values and a full frame restarts from index 0.

Decomposition:
- Package oled_text_pkg holds:
  - constants LINE_LEN=16, NUM_LINES=4, FRAME_LEN=64, ASCII_SPACE=8'h20, ASCII_ZERO=8'h30.
  - the state encoding IDLE/CONV/WAIT_LOW/SEND/DONE.
  - the fixed line strings.
- Sub-module bin_to_bcd (shift-add-3 double dabble).
  - Ports: clock, reset, start, bin[COUNT_W-1:0], done, bcd[11:0].
  - done pulses COUNT_W+1 cycles after start.

Test Plan:
- Reset, mode=0, counts 5/42/999; controller model acks 2 cycles after valid.
  - Byte stream "Counting        Cand 1:     005 Cand 2:     042 Cand 3:     999 ".
  - frame_done pulses once, then idle.
- mode=1 after the first frame → a second frame starts. Bytes 0-15 "Voting          ", bytes 32-63 all 8'h20.
- count_2=1023 (above SAT_VALUE) → bytes 44-46 = "999".
- Change count_1 from 5 to 6 during byte 20 → current frame still shows "005", a second frame follows with "006", frame_done pulses twice.
- Hold sendDone high 10 cycles after ack → sendDataValid stays 0 until sendDone falls. sendData stable during every valid window.
- Assert reset at byte 30 → outputs return to reset values asynchronously. After release, a full 64-byte frame restarts from byte 0 ('C').
